// File: rtl/msrv32_instr_fetch.sv
// msrv32_instr_fetch
//   Instruction-fetch front end. Issues word addresses to instruction memory,
//   captures returned words (with their PCs) into a small prefetch FIFO and
//   presents the FIFO head to decode with a valid/stall handshake. Branch and
//   trap redirects drop everything buffered or in flight and restart fetch at
//   the redirect target; a misaligned target parks the unit until the next
//   redirect.
//
// Ports
//   ms_riscv32_mp_clk_in     : clock, rising edge
//   ms_riscv32_mp_rst_in     : synchronous active-high reset
//   ms_riscv32_mp_imaddr_out : instruction memory word address (bits[1:0]=0)
//   ms_riscv32_mp_imreq_out  : address-phase request valid
//   ms_riscv32_mp_hready_in  : memory accepts imaddr this cycle
//   ms_riscv32_mp_instr_in   : read data, valid one cycle after acceptance
//   redirect_in/_pc_in       : one-cycle redirect pulse and its target
//   stall_in                 : decode not accepting this cycle
//   instr_valid_out          : instr_out/pc_out hold a real instruction
//   instr_out / pc_out       : FIFO head instruction (NOP when empty) and PC
//   flush_out                : ~instr_valid_out
//   misaligned_out           : last redirect target was not word aligned
module msrv32_instr_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic [31:0] ms_riscv32_mp_imaddr_out,
  output logic        ms_riscv32_mp_imreq_out,
  input  logic        ms_riscv32_mp_hready_in,
  input  logic [31:0] ms_riscv32_mp_instr_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic        misaligned_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [31:0]        inflight_pc_q, inflight_pc_d;
  logic               misaligned_q, misaligned_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        instr_mem_d [FIFO_DEPTH];
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];
  logic [31:0]        pc_mem_d    [FIFO_DEPTH];

  logic               head_valid;
  logic               deq;
  logic               enq;
  logic               accept;
  logic               imreq;
  logic               target_misaligned;
  logic [31:0]        occupancy;
  logic               room;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == FIFO_DEPTH - 1) return '0;
    else                          return p + 1'b1;
  endfunction

  assign head_valid        = (count_q != '0);
  assign deq               = head_valid & ~stall_in;
  assign enq               = inflight_q;
  assign accept            = imreq & ms_riscv32_mp_hready_in;
  assign target_misaligned = |redirect_pc_in[1:0];

  // Buffered plus in-flight words must still fit once this cycle's dequeue
  // retires, so an accepted request can never land in a full FIFO.
  assign occupancy = 32'(count_q) + 32'(inflight_q);
  assign room      = occupancy < (FIFO_DEPTH + 32'(deq));

  // State register
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) state_q <= S_BOOT;
    else                      state_q <= state_d;
  end

  // Next-state logic; a redirect wins in every state
  always_comb begin
    state_d = state_q;
    if (redirect_in) begin
      state_d = target_misaligned ? S_HOLD : S_RUN;
    end else begin
      unique case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_BOOT;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    imreq = 1'b0;
    if (state_q == S_RUN && !redirect_in && room) imreq = 1'b1;
  end

  // Datapath next-state
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    misaligned_d  = misaligned_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    instr_mem_d   = instr_mem_q;
    pc_mem_d      = pc_mem_q;

    if (redirect_in) begin
      // Clearing inflight here drops the word returning this cycle; no
      // request is issued during a redirect, so nothing else can be pending.
      fetch_pc_d   = redirect_pc_in;
      misaligned_d = target_misaligned;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (accept) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
      if (enq) begin
        instr_mem_d[wr_ptr_q] = ms_riscv32_mp_instr_in;
        pc_mem_d[wr_ptr_q]    = inflight_pc_q;
        wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      fetch_pc_q    <= BOOT_ADDR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= BOOT_ADDR;
      misaligned_q  <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      instr_mem_q   <= '{default: '0};
      pc_mem_q      <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misaligned_q  <= misaligned_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_mem_q   <= instr_mem_d;
      pc_mem_q      <= pc_mem_d;
    end
  end

  assign ms_riscv32_mp_imreq_out  = imreq;
  assign ms_riscv32_mp_imaddr_out = {fetch_pc_q[31:2], 2'b00};
  assign instr_valid_out          = head_valid;
  assign flush_out                = ~head_valid;
  assign misaligned_out           = misaligned_q;
  assign instr_out                = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
  // With nothing buffered, pc_out shows the next fetch address
  assign pc_out = head_valid ? pc_mem_q[rd_ptr_q] : {fetch_pc_q[31:2], 2'b00};

endmodule
